// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with a small FIFO of {instr, pc, pc+4} entries between
// the PC/IMEM path and decode; an execute redirect flushes the queue and reloads the PC.
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PCSrcE,
    input  logic [XLEN-1:0]            PCTargetE,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_ready,
    input  logic                       dec_ready,
    output logic                       dec_valid,
    output logic [31:0]                InstrD,
    output logic [XLEN-1:0]            PCD,
    output logic [XLEN-1:0]            PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    logic [XLEN-1:0]  r_pc_f;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      r_instr_q [DEPTH];
    logic [XLEN-1:0]  r_pc_q    [DEPTH];
    logic [XLEN-1:0]  r_pc4_q   [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_fetch;
    logic [XLEN-1:0]  w_pc4_f;
    logic [XLEN-1:0]  w_redirect_pc;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_pc4_f       = pc_plus4(r_pc_f);
    // Redirect targets are word aligned; the low two bits are forced to zero.
    assign w_redirect_pc = PCTargetE & ~XLEN'(3);

    assign dec_valid = ~w_empty & ~PCSrcE;
    assign w_pop     = dec_valid & dec_ready;
    assign w_fetch   = ~PCSrcE & imem_ready & (~w_full | w_pop);

    assign imem_addr = r_pc_f;
    assign occupancy = r_count;
    assign InstrD    = w_empty ? '0 : r_instr_q[r_rd_ptr];
    assign PCD       = w_empty ? '0 : r_pc_q[r_rd_ptr];
    assign PCPlus4D  = w_empty ? '0 : r_pc4_q[r_rd_ptr];

    // Control state: PC, pointers and count. Redirect outranks fetch and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f   <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (PCSrcE) begin
            r_pc_f   <= w_redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fetch) begin
                r_pc_f   <= w_pc4_f;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_fetch, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage carries no reset; stale entries are hidden by the empty gating.
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_instr_q[r_wr_ptr] <= imem_rdata;
            r_pc_q[r_wr_ptr]    <= r_pc_f;
            r_pc4_q[r_wr_ptr]   <= w_pc4_f;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: free run, backpressure, full with pop,
// imem stalls, redirect flush, mid-stream reset, and PC wrap on a second instance.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [2:0]  occupancy;

    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_dec_valid;
    logic [31:0] w_InstrD;
    logic [31:0] w_PCD;
    logic [31:0] w_PCPlus4D;
    logic [2:0]  w_occupancy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return a ^ 32'h5A3C_0F11;
    endfunction

    assign imem_rdata   = imem_f(imem_addr);
    assign w_imem_rdata = imem_f(w_imem_addr);

    fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dec_ready(dec_ready), .dec_valid(dec_valid), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .occupancy(occupancy)
    );

    fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .imem_ready(1'b1),
        .dec_ready(1'b1), .dec_valid(w_dec_valid), .InstrD(w_InstrD),
        .PCD(w_PCD), .PCPlus4D(w_PCPlus4D), .occupancy(w_occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(dec_valid), 32'd1);
        chk({tag, ".PCD"}, PCD, pc);
        chk({tag, ".PCPlus4D"}, PCPlus4D, pc + 32'd4);
        chk({tag, ".InstrD"}, InstrD, imem_f(pc));
    endtask

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; imem_ready = 1'b1; dec_ready = 1'b1;
        repeat (2) tick();
        chk("rst.valid", 32'(dec_valid), 32'd0);
        chk("rst.occ", 32'(occupancy), 32'd0);
        chk("rst.InstrD", InstrD, 32'd0);
        chk("rst.PCD", PCD, 32'd0);
        chk("rst.PCPlus4D", PCPlus4D, 32'd0);
        chk("rst.addr", imem_addr, 32'd0);
        chk("wrap.rst.addr", w_imem_addr, 32'hFFFF_FFFC);

        // Free run from reset release.
        rst = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            chk("run.addr", imem_addr, 32'(4 * k));
            if (k == 0) chk("run.valid0", 32'(dec_valid), 32'd0);
            else        chk_head("run", 32'(4 * (k - 1)));
            if (k == 1) begin
                chk("wrap.PCD1", w_PCD, 32'hFFFF_FFFC);
                chk("wrap.PCPlus4D1", w_PCPlus4D, 32'h0);
                chk("wrap.addr1", w_imem_addr, 32'h0);
            end
            if (k == 2) begin
                chk("wrap.PCD2", w_PCD, 32'h0);
                chk("wrap.PCPlus4D2", w_PCPlus4D, 32'h4);
            end
            tick();
        end

        // Backpressure from a fresh reset.
        rst = 1'b1; tick();
        rst = 1'b0; dec_ready = 1'b0; #1;
        chk("bp.addr0", imem_addr, 32'd0);
        chk("bp.occ0", 32'(occupancy), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("bp.occ", 32'(occupancy), (c < 4) ? 32'(c) : 32'd4);
            chk("bp.addr", imem_addr, (c < 4) ? 32'(4 * c) : 32'd16);
            chk_head("bp.hold", 32'd0);
        end

        // Full with simultaneous pop: occupancy stays 4 and fetch continues.
        dec_ready = 1'b1; #1;
        for (int j = 0; j < 6; j++) begin
            chk_head("full", 32'(4 * j));
            chk("full.occ", 32'(occupancy), 32'd4);
            chk("full.addr", imem_addr, 32'(16 + 4 * j));
            if (j < 5) tick();
        end

        // imem not ready for two cycles; pops continue.
        imem_ready = 1'b0; tick();
        chk_head("stall1", 32'd24);
        chk("stall1.addr", imem_addr, 32'd36);
        chk("stall1.occ", 32'(occupancy), 32'd3);
        tick();
        chk_head("stall2", 32'd28);
        chk("stall2.addr", imem_addr, 32'd36);
        chk("stall2.occ", 32'(occupancy), 32'd2);
        imem_ready = 1'b1; tick();
        chk_head("resume1", 32'd32);
        chk("resume1.addr", imem_addr, 32'd40);
        chk("resume1.occ", 32'(occupancy), 32'd2);
        tick();
        chk_head("resume2", 32'd36);
        chk("resume2.addr", imem_addr, 32'd44);

        // Build three entries, then redirect.
        dec_ready = 1'b0; tick();
        chk("q3.occ", 32'(occupancy), 32'd3);
        chk_head("q3", 32'd36);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103; dec_ready = 1'b1; #1;
        chk("redir.same.valid", 32'(dec_valid), 32'd0);
        tick();
        PCSrcE = 1'b0; #1;
        chk("redir.n1.occ", 32'(occupancy), 32'd0);
        chk("redir.n1.addr", imem_addr, 32'h100);
        chk("redir.n1.valid", 32'(dec_valid), 32'd0);
        tick();
        chk_head("redir.n2", 32'h100);
        chk("redir.n2.occ", 32'(occupancy), 32'd1);
        tick();
        chk_head("redir.n3", 32'h104);

        // Reset mid-stream with two entries queued.
        dec_ready = 1'b0; tick();
        chk("mid.occ", 32'(occupancy), 32'd2);
        chk_head("mid.head", 32'h104);
        rst = 1'b1; tick();
        chk("mid.rst.valid", 32'(dec_valid), 32'd0);
        chk("mid.rst.occ", 32'(occupancy), 32'd0);
        chk("mid.rst.addr", imem_addr, 32'd0);
        chk("mid.rst.PCD", PCD, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction fetch stage with a DEPTH-entry instruction queue between fetch and decode, replacing the single fetch/decode pipeline register. It drives the instruction memory address, buffers each fetched {PC, PC+4, instruction} triple, and hands entries to decode with a valid/ready handshake. Decode can therefore stall without losing fetched instructions, and an execute-stage redirect flushes the queue. It sits between the PC/IMEM path and the decode stage.

## Interface

- XLEN, 32: PC width in bits; instruction width is fixed at 32.
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 0: PC value loaded on reset.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- PCSrcE  input  1  redirect request from execute.
- PCTargetE  input  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- imem_addr  output  XLEN  fetch address, equal to the current PC register.
- imem_rdata  input  32  instruction at imem_addr, combinational, same cycle.
- imem_ready  input  1  memory can return data this cycle; when low, no fetch occurs.
- dec_ready  input  1  decode accepts the head entry.
- dec_valid  output  1  head entry is valid.
- InstrD  output  32  head instruction.
- PCD  output  XLEN  head PC.
- PCPlus4D  output  XLEN  head PC + 4.
- occupancy  output  $clog2(DEPTH+1)  number of valid entries.

## Operation

- State:
  - PC register pc_f.
  - DEPTH-entry storage of {instr, pc, pc+4}.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register.
- Definitions:
  - empty = (count == 0).
  - full = (count == DEPTH).
  - pop = dec_valid & dec_ready.
  - fetch = ~PCSrcE & imem_ready & (~full | pop).
- Output drive:
  - dec_valid = ~empty & ~PCSrcE. No entry is consumed in a flush cycle.
  - When empty, InstrD, PCD and PCPlus4D drive 0. Otherwise they drive the entry at the read pointer.
- fetch:
  - Write {imem_rdata, pc_f, pc_f+4} at the write pointer.
  - Increment the write pointer.
  - pc_f <= pc_f + 4, computed modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
- pop: increment the read pointer.
- Count update: count += fetch − pop. Simultaneous fetch and pop leaves count unchanged; this is legal when full.
- Redirect (PCSrcE=1), which takes priority over fetch and pop:
  - pc_f <= {PCTargetE[XLEN-1:2], 2'b00}.
  - Both pointers <= 0.
  - count <= 0.
  - imem_rdata is discarded.
- imem_ready=0: pc_f holds and nothing is written; pop proceeds normally.
- Reset (rst=1 at an edge) has priority over everything:
  - pc_f = RESET_PC.
  - Pointers = 0, count = 0.
  - Queue contents are don't-care; outputs are gated by empty.
  - Reset asserted mid-stream drops all queued entries.

## Timing

- Reset values of outputs:
  - dec_valid = 0, occupancy = 0.
  - InstrD = PCD = PCPlus4D = 0.
  - imem_addr = RESET_PC.
- Fetch-to-decode latency is 1 cycle: a fetch at edge N makes the entry visible from cycle N+1.
- No combinational path from imem_rdata to any output.
- Combinational paths into dec_valid:
  - From PCSrcE only.
  - dec_ready does not affect dec_valid.
- Throughput: 1 instruction per cycle when imem_ready=1, dec_ready=1 and there is no redirect.
- After a redirect at edge N:
  - imem_addr = target in cycle N+1.
  - The first target instruction is at the head in cycle N+2.
- When full and dec_ready=0, fetch stalls and imem_addr holds.
- Occupancy never exceeds DEPTH.
- dec_valid and the head fields are stable while dec_ready=0 and no redirect occurs.

## Test plan

- Reset then free run (RESET_PC=0, imem_ready=1, dec_ready=1):
  - imem_addr = 0, 4, 8, … on successive cycles.
  - dec_valid rises one cycle after reset release.
  - PCD = 0, 4, 8, … with PCPlus4D = PCD+4.
- Backpressure (DEPTH=4, dec_ready=0 for 6 cycles):
  - occupancy reaches 4 and holds.
  - imem_addr holds at 16.
  - On dec_ready=1, PCD = 0, 4, 8, 12, 16 in order with no gap or duplicate.
- Full with simultaneous pop:
  - occupancy stays at 4 while dec_ready=1.
  - Fetch continues every cycle.
- Redirect with 3 entries queued (PCTargetE=0x103):
  - Same cycle: dec_valid=0.
  - Next cycle: occupancy=0 and imem_addr=0x100.
  - The cycle after: PCD=0x100.
  - No pre-redirect entry ever appears.
- imem_ready low for 2 cycles:
  - imem_addr and occupancy are unchanged except for pops.
  - The stream resumes with no skipped PC.
- Reset asserted mid-stream with 2 entries queued:
  - Next cycle: dec_valid=0, occupancy=0, imem_addr=RESET_PC.
- PC wrap (XLEN=32, RESET_PC=0xFFFFFFFC):
  - Second fetched PC is 0x0.
  - PCPlus4D of the first entry is 0x0.
